// File: rtl/iter_divider.sv
// ----------------------------------------------------------------------------
// iter_divider
//
// Multi-cycle radix-2 restoring divider serving the EX-stage DIV/DIVU
// handshake. EX raises start_i with the operands and keeps it high until it
// sees ready_o; one quotient bit is produced per clock, so a divide by a
// nonzero divisor completes 33 edges after the start edge. A zero divisor
// short-circuits to a zero result one edge after the start edge.
//
// Signed operands are converted to magnitudes on entry, the unsigned core
// runs on those, and the signs are re-applied on the final step: the
// quotient takes sign(op1)^sign(op2), the remainder takes sign(op1).
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start
//   opdata1_i     dividend; sampled at start
//   opdata2_i     divisor; sampled at start
//   start_i       request, held by EX until ready_o is seen
//   annul_i       abort the current operation (pipeline flush)
//   result_o      {remainder, quotient}, registered
//   ready_o       result valid, registered
// ----------------------------------------------------------------------------
module iter_divider #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_div_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    input  logic              start_i,
    input  logic              annul_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o
);

    localparam int CW = $clog2(DW);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0] counter;
    logic [DW-1:0] rem;
    logic [DW-1:0] dvd;       // dividend bits shift out, quotient bits shift in
    logic [DW-1:0] divisor;
    logic          sign_q;
    logic          sign_r;

    // Operand magnitudes; |most-negative| wraps to itself, which is the
    // correct unsigned magnitude.
    logic          start_ok;
    logic [DW-1:0] op1_mag;
    logic [DW-1:0] op2_mag;

    assign start_ok = start_i && !annul_i;
    assign op1_mag  = (signed_div_i && opdata1_i[DW-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_mag  = (signed_div_i && opdata2_i[DW-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step. The trial difference is kept one bit wider than the
    // shifted remainder so its MSB is a clean borrow flag.
    logic [DW:0]   rem_sh;
    logic [DW+1:0] diff;
    logic          q_bit;
    logic [DW-1:0] rem_step;
    logic [DW-1:0] dvd_step;
    logic [DW-1:0] quot_final;
    logic [DW-1:0] rem_final;

    assign rem_sh     = {rem, dvd[DW-1]};
    assign diff       = {1'b0, rem_sh} - {2'b00, divisor};
    assign q_bit      = ~diff[DW+1];
    // When the step succeeds the difference is below the divisor, and when it
    // fails the shifted remainder is, so the upper bit is always zero here.
    assign rem_step   = q_bit ? diff[DW-1:0] : rem_sh[DW-1:0];
    assign dvd_step   = {dvd[DW-2:0], q_bit};
    assign quot_final = sign_q ? (~dvd_step + 1'b1) : dvd_step;
    assign rem_final  = sign_r ? (~rem_step + 1'b1) : rem_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = (opdata2_i == '0) ? S_BYZERO : S_RUN;
                end
            end
            S_BYZERO: begin
                state_next = annul_i ? S_IDLE : S_DONE;
            end
            S_RUN: begin
                if (annul_i) begin
                    state_next = S_IDLE;
                end else if (counter == LAST_STEP) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_i || annul_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            rem      <= '0;
            dvd      <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (start_ok) begin
                        dvd     <= op1_mag;
                        divisor <= op2_mag;
                        sign_q  <= signed_div_i && (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                        sign_r  <= signed_div_i && opdata1_i[DW-1];
                        counter <= '0;
                        rem     <= '0;
                    end
                end
                S_BYZERO: begin
                    result_o <= '0;
                    if (!annul_i) begin
                        ready_o <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        rem     <= rem_step;
                        dvd     <= dvd_step;
                        counter <= counter + 1'b1;
                        if (counter == LAST_STEP) begin
                            result_o <= {rem_final, quot_final};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!start_i || annul_i) begin
                        ready_o <= 1'b0;
                    end
                end
                default: ready_o <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// ----------------------------------------------------------------------------
// tb_iter_divider
//
// Directed self-checking bench for iter_divider. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge. Expected
// results are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_iter_divider;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int tests;
    int fails;

    iter_divider #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Runs one divide with start held until ready; edges counts rising edges
    // from the start edge through the one after which ready was seen.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input bit toggle, output logic [63:0] res, output int edges,
                           output logic rdy_after, output logic [63:0] res_after);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        @(negedge clk);
        op1 = a; op2 = b; signed_div = sgn; start = 1'b1;
        while (!seen && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready) begin
                seen = 1'b1;
            end else if (toggle) begin
                op1 = $urandom;
                op2 = $urandom;
                signed_div = 1'($urandom_range(0, 1));
            end
        end
        res = result;
        @(negedge clk);
        start = 1'b0; op1 = '0; op2 = '0;
        @(posedge clk);
        #1;
        rdy_after = ready;
        res_after = result;
    endtask

    task automatic test_reset();
        int highs;
        rst = 1'b1; start = 1'b1; op1 = 32'd10; op2 = 32'd4; signed_div = 1'b0; annul = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", ready); end
        tests++;
        if (result !== 64'd0) begin fails++; $display("FAIL reset_result got=%h want=0", result); end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        highs = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) highs++;
        end
        tests++;
        if (highs !== 0) begin fails++; $display("FAIL reset_no_latch ready_cycles=%0d want=0", highs); end
    endtask

    task automatic test_unsigned();
        logic [63:0] r, ra;
        int e;
        logic rd;
        run_div(32'd100, 32'd7, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000002_0000000E) begin fails++; $display("FAIL u100_7 got=%h want=00000002_0000000e", r); end
        tests++;
        if (e !== 33) begin fails++; $display("FAIL u100_7_latency got=%0d want=33", e); end
        tests++;
        if (rd !== 1'b0) begin fails++; $display("FAIL u100_7_ready_drop got=%b want=0", rd); end
        tests++;
        if (ra !== 64'h00000002_0000000E) begin fails++; $display("FAIL u100_7_held got=%h want=00000002_0000000e", ra); end
        run_div(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000000_FFFFFFFF) begin fails++; $display("FAIL umax_1 got=%h want=00000000_ffffffff", r); end
        run_div(32'hFFFFFFFF, 32'h00010000, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h0000FFFF_0000FFFF) begin fails++; $display("FAIL umax_10000 got=%h want=0000ffff_0000ffff", r); end
        // Same bit patterns as a signed case, but unsigned: 0xFFFFFFF9 / 2.
        run_div(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000001_7FFFFFFC) begin fails++; $display("FAIL u_fff9_2 got=%h want=00000001_7ffffffc", r); end
    endtask

    task automatic test_signed();
        logic [63:0] r, ra;
        int e;
        logic rd;
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL s_m7_2 got=%h want=ffffffff_fffffffd", r); end
        tests++;
        if (e !== 33) begin fails++; $display("FAIL s_m7_2_latency got=%0d want=33", e); end
        run_div(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000001_FFFFFFFD) begin fails++; $display("FAIL s_7_m2 got=%h want=00000001_fffffffd", r); end
        run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'hFFFFFFFE_0000000E) begin fails++; $display("FAIL s_m100_m7 got=%h want=fffffffe_0000000e", r); end
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000000_80000000) begin fails++; $display("FAIL s_overflow got=%h want=00000000_80000000", r); end
    endtask

    task automatic test_div_zero();
        logic [63:0] r, ra;
        int e;
        logic rd;
        run_div(32'd5, 32'd0, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'd0) begin fails++; $display("FAIL dz_result got=%h want=0", r); end
        tests++;
        if (e !== 2) begin fails++; $display("FAIL dz_latency got=%0d want=2", e); end
        tests++;
        if (rd !== 1'b0) begin fails++; $display("FAIL dz_ready_drop got=%b want=0", rd); end
        run_div(32'd9, 32'd3, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000000_00000003) begin fails++; $display("FAIL b2b_9_3 got=%h want=00000000_00000003", r); end
        tests++;
        if (e !== 33) begin fails++; $display("FAIL b2b_9_3_latency got=%0d want=33", e); end
    endtask

    task automatic test_annul();
        logic [63:0] r, ra;
        int e, highs;
        logic rd;
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (result !== 64'd0) begin fails++; $display("FAIL annul_result got=%h want=0", result); end
        @(negedge clk);
        annul = 1'b0;
        highs = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready) highs++;
        end
        tests++;
        if (highs !== 0) begin fails++; $display("FAIL annul_no_ready ready_cycles=%0d want=0", highs); end
        run_div(32'd1000, 32'd3, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000001_0000014D) begin fails++; $display("FAIL annul_rerun got=%h want=00000001_0000014d", r); end
        tests++;
        if (e !== 33) begin fails++; $display("FAIL annul_rerun_latency got=%0d want=33", e); end
    endtask

    task automatic test_operand_stability();
        logic [63:0] r, ra;
        int e;
        logic rd;
        run_div(32'd1000, 32'd3, 1'b0, 1'b1, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000001_0000014D) begin fails++; $display("FAIL stable_u got=%h want=00000001_0000014d", r); end
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, r, e, rd, ra);
        tests++;
        if (r !== 64'hFFFFFFFF_FFFFFFFD) begin fails++; $display("FAIL stable_s got=%h want=ffffffff_fffffffd", r); end
    endtask

    task automatic test_reset_midop();
        logic [63:0] r, ra;
        int e;
        logic rd;
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (ready !== 1'b0) begin fails++; $display("FAIL midrst_ready got=%b want=0", ready); end
        tests++;
        if (result !== 64'd0) begin fails++; $display("FAIL midrst_result got=%h want=0", result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        run_div(32'd10, 32'd4, 1'b0, 1'b0, r, e, rd, ra);
        tests++;
        if (r !== 64'h00000002_00000002) begin fails++; $display("FAIL midrst_rerun got=%h want=00000002_00000002", r); end
        tests++;
        if (e !== 33) begin fails++; $display("FAIL midrst_rerun_latency got=%0d want=33", e); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_operand_stability();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
